// File: rtl/alu_datamem_stage.sv
// Execute and memory-access slice of the single-cycle MIPS datapath.
// It decodes the ALU operation, runs the 32-bit ALU and provides a word-organised
// data memory that is addressed by the ALU result.
module alu_datamem_stage #(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_BITS = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  aluop,
   input  logic [5:0]  funct,
   input  logic [4:0]  shamt,
   input  logic [31:0] read_data1,
   input  logic [31:0] read_data2,
   input  logic [31:0] imm_ext,
   input  logic        alusrc,
   input  logic        memread,
   input  logic        memwrite,
   output logic [3:0]  alu_control,
   output logic        jump_reg,
   output logic [31:0] alu_result,
   output logic        zero,
   output logic [31:0] mem_read_data
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_SLL = 4'b1000;
   localparam logic [3:0] ALU_SRL = 4'b1001;

   logic [31:0]          operand_b;
   logic [ADDR_BITS-1:0] mem_idx;
   logic [31:0]          mem_q [MEM_WORDS];

   // Decode the ALU operation from aluop and funct; jr is an R-type ADD that also raises jump_reg.
   always_comb begin
      alu_control = ALU_ADD;
      jump_reg    = 1'b0;
      case (aluop)
         2'b00: alu_control = ALU_ADD;
         2'b01: alu_control = ALU_SUB;
         2'b11: alu_control = ALU_OR;
         default: begin
            case (funct)
               6'b100000: alu_control = ALU_ADD;
               6'b100010: alu_control = ALU_SUB;
               6'b100100: alu_control = ALU_AND;
               6'b100101: alu_control = ALU_OR;
               6'b100111: alu_control = ALU_NOR;
               6'b101010: alu_control = ALU_SLT;
               6'b000000: alu_control = ALU_SLL;
               6'b000010: alu_control = ALU_SRL;
               6'b001000: begin
                  alu_control = ALU_ADD;
                  jump_reg    = 1'b1;
               end
               default:   alu_control = ALU_ADD;
            endcase
         end
      endcase
   end

   // The ALU proper. Shifts operate on operand B by shamt, and undefined codes give zero.
   always_comb begin
      operand_b  = alusrc ? imm_ext : read_data2;
      alu_result = 32'h0;
      case (alu_control)
         ALU_AND: alu_result = read_data1 & operand_b;
         ALU_OR:  alu_result = read_data1 | operand_b;
         ALU_ADD: alu_result = read_data1 + operand_b;
         ALU_SUB: alu_result = read_data1 - operand_b;
         ALU_SLT: alu_result = ($signed(read_data1) < $signed(operand_b)) ? 32'd1 : 32'd0;
         ALU_NOR: alu_result = ~(read_data1 | operand_b);
         ALU_SLL: alu_result = operand_b << shamt;
         ALU_SRL: alu_result = operand_b >> shamt;
         default: alu_result = 32'h0;
      endcase
   end

   assign zero = (alu_result == 32'h0);

   // Word index ignores the byte offset and any high address bits, so addresses wrap around the array.
   always_comb begin
      mem_idx       = alu_result[ADDR_BITS+1:2];
      mem_read_data = memread ? mem_q[mem_idx] : 32'h0;
   end

   // Storage update: reset clears every word and takes priority over a store in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem_q[i] <= 32'h0;
         end
      end else if (memwrite) begin
         mem_q[mem_idx] <= read_data2;
      end
   end

endmodule

// File: tb/tb_alu_datamem_stage.sv
// Directed bench for alu_datamem_stage. Each step drives the inputs, queues the expected
// outputs, and checks them on the falling edge before the rising edge commits any store.
module tb_alu_datamem_stage;

   logic        clk;
   logic        reset;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [4:0]  shamt;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [31:0] imm_ext;
   logic        alusrc;
   logic        memread;
   logic        memwrite;
   logic [3:0]  alu_control;
   logic        jump_reg;
   logic [31:0] alu_result;
   logic        zero;
   logic [31:0] mem_read_data;

   typedef enum int {SEL_RESULT, SEL_ZERO, SEL_CTRL, SEL_JR, SEL_MEM} sel_e;

   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t scoreboard[$];
   int   compare_count  = 0;
   int   mismatch_count = 0;

   alu_datamem_stage #(.MEM_WORDS(256), .ADDR_BITS(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .aluop         (aluop),
      .funct         (funct),
      .shamt         (shamt),
      .read_data1    (read_data1),
      .read_data2    (read_data2),
      .imm_ext       (imm_ext),
      .alusrc        (alusrc),
      .memread       (memread),
      .memwrite      (memwrite),
      .alu_control   (alu_control),
      .jump_reg      (jump_reg),
      .alu_result    (alu_result),
      .zero          (zero),
      .mem_read_data (mem_read_data)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] observe(sel_e sel);
      case (sel)
         SEL_RESULT: return alu_result;
         SEL_ZERO:   return {31'h0, zero};
         SEL_CTRL:   return {28'h0, alu_control};
         SEL_JR:     return {31'h0, jump_reg};
         default:    return mem_read_data;
      endcase
   endfunction

   task automatic apply_stimulus(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                 input logic src, input logic rd, input logic wr, input logic rst_n);
      aluop      = op;
      funct      = fn;
      shamt      = sh;
      read_data1 = a;
      read_data2 = b;
      imm_ext    = imm;
      alusrc     = src;
      memread    = rd;
      memwrite   = wr;
      reset      = rst_n;
   endtask

   task automatic push_exp(input string tag, input sel_e sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      scoreboard.push_back(e);
   endtask

   // Compare everything queued for this step on the falling edge, then let the rising edge commit.
   task automatic check_output();
      exp_t        e;
      logic [31:0] obs;
      @(negedge clk);
      while (scoreboard.size() > 0) begin
         e   = scoreboard.pop_front();
         obs = observe(e.sel);
         compare_count++;
         assert (obs === e.exp) else begin
            mismatch_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // Memory is cleared after reset, at any address.
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_exp("rst_mem0", SEL_MEM, 32'h0);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h3FC, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      push_exp("rst_mem3fc", SEL_MEM, 32'h0);
      check_output();

      // R-type arithmetic and logic.
      apply_stimulus(2'b10, 6'b100000, 5'd0, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("add_res", SEL_RESULT, 32'd12);
      push_exp("add_zero", SEL_ZERO, 32'd0);
      push_exp("add_ctrl", SEL_CTRL, 32'b0010);
      push_exp("add_jr", SEL_JR, 32'd0);
      check_output();
      apply_stimulus(2'b10, 6'b100010, 5'd0, 32'd9, 32'd9, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("sub_res", SEL_RESULT, 32'd0);
      push_exp("sub_zero", SEL_ZERO, 32'd1);
      push_exp("sub_ctrl", SEL_CTRL, 32'b0110);
      check_output();
      apply_stimulus(2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("slt_neg", SEL_RESULT, 32'd1);
      push_exp("slt_ctrl", SEL_CTRL, 32'b0111);
      check_output();
      apply_stimulus(2'b10, 6'b101010, 5'd0, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("slt_pos", SEL_RESULT, 32'd0);
      check_output();
      apply_stimulus(2'b10, 6'b100111, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("nor_res", SEL_RESULT, 32'hFFFF_FFFF);
      push_exp("nor_ctrl", SEL_CTRL, 32'b1100);
      check_output();
      apply_stimulus(2'b10, 6'b100100, 5'd0, 32'hF0F0_1234, 32'h0FF0_00FF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("and_res", SEL_RESULT, 32'h00F0_0034);
      check_output();
      apply_stimulus(2'b10, 6'b100101, 5'd0, 32'hF000_0000, 32'h0000_000F, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("or_res", SEL_RESULT, 32'hF000_000F);
      check_output();
      apply_stimulus(2'b10, 6'b111111, 5'd0, 32'd3, 32'd4, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("undef_fn_ctrl", SEL_CTRL, 32'b0010);
      push_exp("undef_fn_res", SEL_RESULT, 32'd7);
      check_output();

      // Shifts and jr.
      apply_stimulus(2'b10, 6'b000000, 5'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("sll_res", SEL_RESULT, 32'h10);
      push_exp("sll_ctrl", SEL_CTRL, 32'b1000);
      check_output();
      apply_stimulus(2'b10, 6'b000010, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("srl_res", SEL_RESULT, 32'h1);
      push_exp("srl_ctrl", SEL_CTRL, 32'b1001);
      check_output();
      apply_stimulus(2'b10, 6'b001000, 5'd0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("jr_flag", SEL_JR, 32'd1);
      push_exp("jr_ctrl", SEL_CTRL, 32'b0010);
      check_output();
      apply_stimulus(2'b00, 6'b001000, 5'd0, 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("jr_lw_flag", SEL_JR, 32'd0);
      check_output();

      // Branch compare and immediate OR.
      apply_stimulus(2'b01, 6'h0, 5'd0, 32'h77, 32'h77, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      push_exp("beq_zero", SEL_ZERO, 32'd1);
      check_output();
      apply_stimulus(2'b11, 6'h0, 5'd0, 32'hF0, 32'h0, 32'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
      push_exp("ori_res", SEL_RESULT, 32'hFF);
      push_exp("ori_ctrl", SEL_CTRL, 32'b0001);
      check_output();

      // Store then load at 0x108; the read shows the old word during the store cycle.
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'd8, 1'b1, 1'b1, 1'b1, 1'b1);
      push_exp("st_addr", SEL_RESULT, 32'h108);
      push_exp("st_old", SEL_MEM, 32'h0);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h100, 32'h0, 32'd8, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("ld_new", SEL_MEM, 32'hDEAD_BEEF);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h100, 32'h0, 32'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      push_exp("ld_noread", SEL_MEM, 32'h0);
      check_output();

      // Alignment and wrap: byte offsets and address bits above the index are ignored.
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h4, 32'h1234, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h5, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("wrap_5", SEL_MEM, 32'h1234);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h7, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("wrap_7", SEL_MEM, 32'h1234);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h404, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("wrap_404", SEL_MEM, 32'h1234);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h8, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("neighbour_8", SEL_MEM, 32'h0);
      check_output();

      // Reset with a concurrent store: everything clears and the store is discarded.
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h3FC, 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h8, 32'h99, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h108, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("clr_108", SEL_MEM, 32'h0);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h4, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("clr_4", SEL_MEM, 32'h0);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h3FC, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("clr_3fc", SEL_MEM, 32'h0);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'h8, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("rst_drop_wr", SEL_MEM, 32'h0);
      check_output();

      // Normal stores resume once reset is released.
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'hC, 32'h55, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1);
      check_output();
      apply_stimulus(2'b00, 6'h0, 5'd0, 32'hC, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1);
      push_exp("post_rst_55", SEL_MEM, 32'h55);
      check_output();

      $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
      $finish;
   end

endmodule

// File: doc/alu_datamem_stage.md
Name: alu_datamem_stage

Overview:
- Execute plus memory-access slice of the single-cycle MIPS datapath.
- Decodes ALU operation from aluop/funct, performs the 32-bit ALU operation (second operand selected by alusrc), and flags jr.
- Provides a word-organised data memory addressed by the ALU result.
- Sits between RegisterFile/signExtention outputs and the writeback mux (mux_41) and PC-select logic.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in data memory (power of two).
- ADDR_BITS, 8, log2(MEM_WORDS); word index taken from alu_result[ADDR_BITS+1:2].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (sampled on rising clk edge)
- aluop  input  2  from control unit: 00 lw/sw, 01 beq, 10 R-type, 11 immediate-OR
- funct  input  6  instruction[5:0]
- shamt  input  5  instruction[10:6]
- read_data1  input  32  register rs value (operand A)
- read_data2  input  32  register rt value (operand B / store data)
- imm_ext  input  32  sign-extended immediate
- alusrc  input  1  0: B=read_data2, 1: B=imm_ext
- memread  input  1  data-memory read enable
- memwrite  input  1  data-memory write enable
- alu_control  output  4  decoded ALU operation code
- jump_reg  output  1  high for R-type jr
- alu_result  output  32  ALU result, also the memory byte address
- zero  output  1  high when alu_result == 0
- mem_read_data  output  32  data-memory read value

Behaviour:
- ALU control, combinational. Codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, SLL 1000, SRL 1001.
- aluop=00 gives ADD; 01 gives SUB; 11 gives OR.
- aluop=10 decodes funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL, 001000 ADD with jump_reg=1. Any other funct gives ADD.
- jump_reg=1 only for aluop=10 and funct=001000; otherwise 0.
- ALU, combinational. A=read_data1; B per alusrc.
  - ADD/SUB: modulo 2^32, no overflow flag or trap.
  - SLT: signed compare, result 1 or 0.
  - SLL/SRL: shift B by shamt; SRL is logical (zero fill). A is ignored.
  - Undefined alu_control codes give 0.
  - zero = (alu_result == 0), for every operation.
- Data memory: MEM_WORDS x 32 array.
  - Word index = alu_result[ADDR_BITS+1:2]. Address bits [1:0] and bits above ADDR_BITS+1 are ignored, so the address wraps modulo MEM_WORDS words.
  - Write: on rising clk edge, when reset=1 and memwrite=1, store read_data2 at the index.
  - Read: combinational. mem_read_data = array[index] when memread=1, else 32'h0.
  - memread and memwrite together at the same index: mem_read_data shows the old word until the edge, then the new word.
  - Reset: on a rising edge with reset=0, every word clears to 0 and any write that cycle is ignored. Reset has priority over memwrite.
  - ALU and ALU-control outputs are purely combinational, with no reset dependency.
- Reset value of outputs: after reset with memread=1, mem_read_data=0 for any address. Other outputs follow their inputs with zero latency.
- Latency: all outputs 0 cycles; memory writes become visible the cycle after the write edge.

Test Plan:
- R-type arithmetic and logic:
  - aluop=10, funct=100000, A=5, B=7, alusrc=0 -> alu_result=12, zero=0, alu_control=0010.
  - funct=100010 with A=B=9 -> alu_result=0, zero=1.
  - funct=101010 with A=0xFFFFFFFF, B=1 -> alu_result=1 (signed compare).
  - funct=100111 with A=0, B=0 -> alu_result=0xFFFFFFFF.
- Shifts and jr:
  - funct=000000, shamt=4, B=0x1 -> alu_result=0x10.
  - funct=000010, shamt=31, B=0x80000000 -> alu_result=1.
  - funct=001000 -> jump_reg=1. aluop=00 with the same funct -> jump_reg=0.
- Store/load:
  - Store cycle: aluop=00, alusrc=1, A=0x100, imm_ext=8, read_data2=0xDEADBEEF, memwrite=1.
  - Next cycle: memread=1, same address -> mem_read_data=0xDEADBEEF. memread=0 -> 0.
- Address wrap and alignment:
  - Write 0x1234 at byte address 0x4 -> read at 0x5, 0x7 and 0x404 (256 words) each returns 0x1234.
- Reset:
  - After filling several words, assert reset=0 for one edge with memwrite=1 -> all reads return 0 and the concurrent write is discarded.
  - Deassert reset, write 0x55 -> readback 0x55.
- Branch and immediate:
  - aluop=01, A=B=0x77 -> zero=1.
  - aluop=11, alusrc=1, A=0xF0, imm_ext=0x0F -> alu_result=0xFF.
